// File: rtl/cpu65_pkg.sv
// cpu65_pkg: types and constants shared by the 65C02 datapath blocks.
//   pc_op_t      - per-CPU-cycle operation code for the program counter
//   pc_state_t   - program counter branch-fix FSM states
//   PHASE_STEP   - q value at which CPU-cycle state commits
//   RESET_VECTOR - PC value loaded by reset (reset vector fetch address)
package cpu65_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'b000,
    INC     = 3'b001,
    LOAD_L  = 3'b010,
    LOAD_H  = 3'b011,
    LOAD_HL = 3'b100,
    BRANCH  = 3'b101
  } pc_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    FIX  = 1'b1
  } pc_state_t;

  localparam logic [1:0]  PHASE_STEP   = 2'b00;
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

endpackage

// File: rtl/program_counter.sv
// program_counter: 16-bit PC stage feeding the address bus stage.
// Commits once per CPU cycle on the fclk edge where q == PHASE_STEP.
//   fclk          in   fast system clock
//   resb          in   synchronous active-low reset
//   q             in   CPU-cycle phase (0..3)
//   pc_op         in   operation for this CPU cycle (pc_op_t encoding)
//   pcl_bus_in    in   low byte returned from the address bus stage
//   pch_bus_in    in   high byte returned from the address bus stage
//   branch_offset in   signed relative branch displacement
//   pcl_out       out  PC low byte (registered)
//   pch_out       out  PC high byte (registered)
//   fix_pending   out  high while the branch page-fix cycle is outstanding
//   page_cross    out  one-fclk pulse after a page-crossing branch step
module program_counter
  import cpu65_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_VECTOR
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic [1:0] q,
  input  logic [2:0] pc_op,
  input  logic [7:0] pcl_bus_in,
  input  logic [7:0] pch_bus_in,
  input  logic [7:0] branch_offset,
  output logic [7:0] pcl_out,
  output logic [7:0] pch_out,
  output logic       fix_pending,
  output logic       page_cross
);

  pc_state_t   state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic        dir_back_reg, dir_back_next;   // 1: pending fix decrements PCH
  logic        fix_reg, fix_next;
  logic        cross_reg, cross_next;
  logic [8:0]  sum9;

  always_ff @(posedge fclk) begin
    if (!resb) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      dir_back_reg <= 1'b0;
      fix_reg      <= 1'b0;
      cross_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      dir_back_reg <= dir_back_next;
      fix_reg      <= fix_next;
      cross_reg    <= cross_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    dir_back_next = dir_back_reg;
    fix_next      = fix_reg;
    cross_next    = 1'b0;         // pulse lasts only the fclk after the step
    // With the offset sign-extended to 9 bits, bit 8 of the sum flags a page
    // crossing in both directions (carry forward, borrow backward).
    sum9 = {1'b0, pc_reg[7:0]} + {branch_offset[7], branch_offset};

    if (q == PHASE_STEP) begin
      case (state_reg)
        IDLE: begin
          case (pc_op)
            INC:     pc_next = pc_reg + 16'd1;
            LOAD_L:  pc_next[7:0]  = pcl_bus_in;
            LOAD_H:  pc_next[15:8] = pch_bus_in;
            LOAD_HL: pc_next = {pch_bus_in, pcl_bus_in};
            BRANCH: begin
              pc_next[7:0] = sum9[7:0];
              if (sum9[8]) begin
                state_next    = FIX;
                fix_next      = 1'b1;
                cross_next    = 1'b1;
                dir_back_next = branch_offset[7];
              end
            end
            default: ;                // HOLD and reserved codes
          endcase
        end
        FIX: begin
          // pc_op is ignored while completing the page fix
          pc_next[15:8] = dir_back_reg ? (pc_reg[15:8] - 8'd1)
                                       : (pc_reg[15:8] + 8'd1);
          fix_next   = 1'b0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign pcl_out     = pc_reg[7:0];
  assign pch_out     = pc_reg[15:8];
  assign fix_pending = fix_reg;
  assign page_cross  = cross_reg;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed self-checking bench for program_counter.
module tb_program_counter;
  import cpu65_pkg::*;

  logic       fclk = 1'b0;
  logic       resb = 1'b0;
  logic [1:0] q = 2'b00;
  logic [2:0] pc_op = 3'b000;
  logic [7:0] pcl_bus_in = 8'h00;
  logic [7:0] pch_bus_in = 8'h00;
  logic [7:0] branch_offset = 8'h00;
  logic [7:0] pcl_out, pch_out;
  logic       fix_pending, page_cross;

  int n_compared = 0;
  int n_mismatched = 0;

  program_counter dut (
    .fclk(fclk), .resb(resb), .q(q), .pc_op(pc_op),
    .pcl_bus_in(pcl_bus_in), .pch_bus_in(pch_bus_in),
    .branch_offset(branch_offset),
    .pcl_out(pcl_out), .pch_out(pch_out),
    .fix_pending(fix_pending), .page_cross(page_cross)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) q <= q + 2'd1;

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Wait for a falling edge just before a step edge (q == 0 sampled next).
  task automatic align_step();
    int guard;
    guard = 0;
    @(negedge fclk);
    while (q != PHASE_STEP && guard < 8) begin
      @(negedge fclk);
      guard++;
    end
    if (guard >= 8) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL align: q stuck at %0d, required 0", q);
    end
  endtask

  // Present one operation on a step edge, sample #1 after it, return to HOLD.
  task automatic do_step(input logic [2:0] op, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] off);
    align_step();
    pc_op = op; pch_bus_in = h; pcl_bus_in = l; branch_offset = off;
    @(posedge fclk);
    #1;
    pc_op = HOLD;
  endtask

  function automatic logic [15:0] pc_now();
    return {pch_out, pcl_out};
  endfunction

  initial begin
    // Reset held low across two full steps
    resb = 1'b0;
    repeat (8) @(posedge fclk);
    #1;
    check_val("rst_pc", pc_now(), 16'hFFFC);
    check_val("rst_fix", {15'd0, fix_pending}, 16'd0);
    check_val("rst_cross", {15'd0, page_cross}, 16'd0);
    @(negedge fclk);
    resb = 1'b1;

    do_step(INC, 8'h00, 8'h00, 8'h00);
    check_val("inc_fffd", pc_now(), 16'hFFFD);
    do_step(LOAD_HL, 8'hFF, 8'hFF, 8'h00);
    do_step(INC, 8'h00, 8'h00, 8'h00);
    check_val("inc_wrap", pc_now(), 16'h0000);

    // Phase gating: INC only on the q=1..3 edges must not move the PC
    do_step(LOAD_HL, 8'h12, 8'h34, 8'h00);
    check_val("load_1234", pc_now(), 16'h1234);
    @(negedge fclk);
    pc_op = INC;
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    pc_op = HOLD;
    check_val("gated_inc", pc_now(), 16'h1234);
    do_step(INC, 8'h00, 8'h00, 8'h00);
    check_val("step_inc", pc_now(), 16'h1235);

    // Byte and word loads, reserved codes
    do_step(LOAD_HL, 8'hC0, 8'h00, 8'h00);
    check_val("load_hl", pc_now(), 16'hC000);
    do_step(LOAD_L, 8'hAA, 8'h55, 8'h00);
    check_val("load_l", pc_now(), 16'hC055);
    do_step(LOAD_H, 8'h80, 8'h11, 8'h00);
    check_val("load_h", pc_now(), 16'h8055);
    do_step(3'b111, 8'h12, 8'h34, 8'h7F);
    check_val("rsvd_111", pc_now(), 16'h8055);
    do_step(3'b110, 8'h12, 8'h34, 8'h7F);
    check_val("rsvd_110", pc_now(), 16'h8055);

    // Branch within the page
    do_step(LOAD_HL, 8'h02, 8'h10, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'hF0);
    check_val("br_nc_pc", pc_now(), 16'h0200);
    check_val("br_nc_cross", {15'd0, page_cross}, 16'd0);
    check_val("br_nc_fix", {15'd0, fix_pending}, 16'd0);

    // Forward crossing with one-fclk pulse
    do_step(LOAD_HL, 8'h02, 8'hF0, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'h20);
    check_val("br_fw_pc", pc_now(), 16'h0210);
    check_val("br_fw_fix", {15'd0, fix_pending}, 16'd1);
    check_val("br_fw_cross", {15'd0, page_cross}, 16'd1);
    @(posedge fclk);
    #1;
    check_val("br_fw_pulse_end", {15'd0, page_cross}, 16'd0);
    check_val("br_fw_hold", pc_now(), 16'h0210);
    do_step(HOLD, 8'h00, 8'h00, 8'h00);
    check_val("br_fw_fixed", pc_now(), 16'h0310);
    check_val("br_fw_fix_clr", {15'd0, fix_pending}, 16'd0);

    // Backward crossing; op on the fix step is ignored
    do_step(LOAD_HL, 8'h03, 8'h05, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'hF0);
    check_val("br_bw_pc", pc_now(), 16'h03F5);
    check_val("br_bw_fix", {15'd0, fix_pending}, 16'd1);
    do_step(LOAD_HL, 8'hAA, 8'hBB, 8'h00);
    check_val("br_bw_fixed", pc_now(), 16'h02F5);

    // Max positive offset: crossing and not crossing
    do_step(LOAD_HL, 8'h00, 8'hF0, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'h7F);
    check_val("br_7f_mid", pc_now(), 16'h006F);
    do_step(HOLD, 8'h00, 8'h00, 8'h00);
    check_val("br_7f_fixed", pc_now(), 16'h016F);
    do_step(LOAD_HL, 8'hFF, 8'h80, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'h7F);
    check_val("br_ffff", pc_now(), 16'hFFFF);
    check_val("br_ffff_fix", {15'd0, fix_pending}, 16'd0);

    // Zero offset
    do_step(LOAD_HL, 8'h12, 8'h34, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'h00);
    check_val("br_zero", pc_now(), 16'h1234);
    check_val("br_zero_fix", {15'd0, fix_pending}, 16'd0);

    // Reset abandons a pending fix
    do_step(LOAD_HL, 8'hFF, 8'hF0, 8'h00);
    do_step(BRANCH, 8'h00, 8'h00, 8'h20);
    check_val("br_rst_mid", pc_now(), 16'hFF10);
    @(negedge fclk);
    resb = 1'b0;
    @(posedge fclk);
    #1;
    check_val("rst_fix_pc", pc_now(), 16'hFFFC);
    check_val("rst_fix_pend", {15'd0, fix_pending}, 16'd0);
    @(negedge fclk);
    resb = 1'b1;
    do_step(HOLD, 8'h00, 8'h00, 8'h00);
    check_val("rst_idle", pc_now(), 16'hFFFC);
    do_step(INC, 8'h00, 8'h00, 8'h00);
    check_val("rst_inc", pc_now(), 16'hFFFD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
